// File: rtl/fpu_sp_issuer_pkg.sv
// Shared definitions for the FPU command issuer: command encodings, FSM states
// and the response FIFO entry layout.
package fpu_sp_issuer_pkg;

    localparam logic [3:0] CMD_FPU_SP_ADD = 4'd1;
    localparam logic [3:0] CMD_FPU_SP_MUL = 4'd2;
    localparam logic [3:0] CMD_FPU_SP_DIV = 4'd3;
    localparam logic [3:0] CMD_FPU_SP_I2F = 4'd4;
    localparam logic [3:0] CMD_FPU_SP_F2I = 4'd5;

    // Widest tag the response entry can carry; narrower tags are zero-extended.
    localparam int RSP_TAG_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        PUSH  = 2'd3
    } issuer_state_e;

    typedef struct packed {
        logic                 err;
        logic [RSP_TAG_W-1:0] tag;
        logic [31:0]          result;
    } rsp_entry_t;

    function automatic logic is_legal_cmd(input logic [3:0] cmd);
        case (cmd)
            CMD_FPU_SP_ADD, CMD_FPU_SP_MUL, CMD_FPU_SP_DIV,
            CMD_FPU_SP_I2F, CMD_FPU_SP_F2I: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fpu_sp_issuer_fifo.sv
// Synchronous first-word-fall-through FIFO with an occupancy count output.
// Read data is forced to zero while the FIFO is empty.
module fpu_rsp_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             valid_o,
    output logic [PTR_W:0]   count_o
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign do_push = push_i && (count_q != FULL_CNT);
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign valid_o = (count_q != '0);
    assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/fpu_sp_issuer.sv
// Host-side command initiator for fpu_sp_top: issues one tagged operation at a
// time, waits for rdy or times out, and queues tagged results for the host.
module fpu_sp_issuer
    import fpu_sp_issuer_pkg::*;
#(
    parameter int TAG_W     = 4,
    parameter int RSP_DEPTH = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_cmd,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic [3:0]       fpu_cmd,
    output logic [31:0]      fpu_din1,
    output logic [31:0]      fpu_din2,
    output logic             fpu_dval,
    input  logic [31:0]      fpu_result,
    input  logic             fpu_rdy
);

    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(RSP_DEPTH);

    issuer_state_e    state_q, state_d;
    logic [3:0]       cmd_q, cmd_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      result_q, result_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    rsp_entry_t       push_entry, head_entry;
    logic             push_en;
    logic             pop_en;
    logic [PTR_W:0]   fifo_count;
    logic             unused_head_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            tag_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            a_q      <= a_d;
            b_q      <= b_d;
            tag_q    <= tag_d;
            result_q <= result_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        a_d      = a_q;
        b_d      = b_q;
        tag_d    = tag_q;
        result_d = result_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    cmd_d = req_cmd;
                    a_d   = req_a;
                    b_d   = req_b;
                    tag_d = req_tag;
                    if (is_legal_cmd(req_cmd)) begin
                        state_d = ISSUE;
                    end else begin
                        err_d    = 1'b1;
                        result_d = '0;
                        state_d  = PUSH;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            // A completion in the same cycle as the last timeout count still wins.
            WAIT: begin
                if (fpu_rdy) begin
                    result_d = fpu_result;
                    err_d    = 1'b0;
                    state_d  = PUSH;
                end else if (cnt_q == CNT_LAST) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = PUSH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The FIFO already counts the finished op by the time the FSM is back in
    // IDLE, so a free slot here guarantees room for the next completion.
    always_comb begin
        req_ready = 1'b0;
        fpu_dval  = 1'b0;
        push_en   = 1'b0;
        if (!rst) begin
            req_ready = (state_q == IDLE) && (fifo_count < DEPTH_CNT);
            fpu_dval  = (state_q == ISSUE);
            push_en   = (state_q == PUSH);
        end
    end

    always_comb begin
        push_entry        = '0;
        push_entry.err    = err_q;
        push_entry.tag    = RSP_TAG_W'(tag_q);
        push_entry.result = result_q;
    end

    assign fpu_cmd  = cmd_q;
    assign fpu_din1 = a_q;
    assign fpu_din2 = b_q;
    assign pop_en   = rsp_valid && rsp_ready;

    fpu_rsp_fifo #(
        .WIDTH ($bits(rsp_entry_t)),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_en),
        .wdata_i (push_entry),
        .pop_i   (pop_en),
        .rdata_o (head_entry),
        .valid_o (rsp_valid),
        .count_o (fifo_count)
    );

    assign rsp_result      = head_entry.result;
    assign rsp_err         = head_entry.err;
    assign rsp_tag         = head_entry.tag[TAG_W-1:0];
    assign unused_head_tag = ^head_entry.tag;

endmodule

// File: tb/tb_fpu_sp_issuer.sv
// Directed bench for fpu_sp_issuer: a behavioural FPU responder with hand-coded
// results, a response monitor, and a linear sequence of checked scenarios.
module tb_fpu_sp_issuer;
    import fpu_sp_issuer_pkg::*;

    localparam int TAG_W   = 4;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic             clk;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_cmd;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [TAG_W-1:0] req_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;
    logic [3:0]       fpu_cmd;
    logic [31:0]      fpu_din1;
    logic [31:0]      fpu_din2;
    logic             fpu_dval;
    logic [31:0]      fpu_result;
    logic             fpu_rdy;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    bit withholdRdy = 1'b0;

    logic [36:0] rspQ[$];
    int          rspCycles[$];
    int          dvalCycles[$];
    int          rdyCycles[$];

    fpu_sp_issuer #(
        .TAG_W     (TAG_W),
        .RSP_DEPTH (DEPTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cmd    (req_cmd),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_tag    (rsp_tag),
        .rsp_err    (rsp_err),
        .fpu_cmd    (fpu_cmd),
        .fpu_din1   (fpu_din1),
        .fpu_din2   (fpu_din2),
        .fpu_dval   (fpu_dval),
        .fpu_result (fpu_result),
        .fpu_rdy    (fpu_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Hand-computed IEEE-754 results for the operand pairs used below.
    function automatic logic [31:0] fpuModel(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
        if (c == CMD_FPU_SP_ADD && x == 32'h3F000000 && y == 32'hBEE00000) return 32'h3D800000;
        if (c == CMD_FPU_SP_MUL && x == 32'h3F000000 && y == 32'hBEE00000) return 32'hBE600000;
        if (c == CMD_FPU_SP_I2F && x == 32'h00000005)                      return 32'h40A00000;
        if (c == CMD_FPU_SP_ADD && x == 32'h3F800000 && y == 32'h3F800000) return 32'h40000000;
        return x ^ y;
    endfunction

    // One-cycle FPU: rdy arrives the cycle after dval unless withheld.
    initial begin
        logic [3:0]  c;
        logic [31:0] x, y;
        fpu_rdy    = 1'b0;
        fpu_result = '0;
        forever begin
            @(negedge clk);
            if (fpu_dval && !withholdRdy) begin
                c = fpu_cmd;
                x = fpu_din1;
                y = fpu_din2;
                @(posedge clk);
                #1;
                fpu_result = fpuModel(c, x, y);
                fpu_rdy    = 1'b1;
                @(posedge clk);
                #1;
                fpu_rdy    = 1'b0;
                fpu_result = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (fpu_dval) dvalCycles.push_back(cycle);
            if (fpu_rdy)  rdyCycles.push_back(cycle);
            if (rsp_valid && rsp_ready) begin
                rspQ.push_back({rsp_err, rsp_tag, rsp_result});
                rspCycles.push_back(cycle);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                 input logic [TAG_W-1:0] tag, output int acceptCycle);
        bit accepted = 1'b0;
        acceptCycle = -1;
        @(posedge clk);
        #1;
        req_cmd   = cmd;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        req_valid = 1'b1;
        for (int i = 0; i < 300 && !accepted; i++) begin
            @(negedge clk);
            if (req_ready) begin
                accepted    = 1'b1;
                acceptCycle = cycle;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (accepted) begin
            @(posedge clk);
            #1;
        end else begin
            checkOutput("req_accept", 64'(accepted), 64'd1);
        end
        req_valid = 1'b0;
    endtask

    task automatic waitRsp(input int n, input int limit);
        for (int i = 0; i < limit && rspQ.size() < n; i++) @(negedge clk);
        checkOutput("rsp_count", 64'(rspQ.size()), 64'(n));
    endtask

    function automatic logic [36:0] popEntry();
        if (rspQ.size() == 0) return '1;
        return rspQ.pop_front();
    endfunction

    function automatic void clearLogs();
        rspQ.delete();
        rspCycles.delete();
        dvalCycles.delete();
        rdyCycles.delete();
    endfunction

    initial begin
        int acc;
        int lat;
        bit sawReady;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_cmd   = '0;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        rsp_ready = 1'b0;

        // Reset values while rst is held.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
        checkOutput("rst_fpu_dval",  64'(fpu_dval),  64'd0);
        checkOutput("rst_fpu_cmd",   64'(fpu_cmd),   64'd0);
        checkOutput("rst_fpu_din",   {fpu_din1, fpu_din2}, 64'd0);
        checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("rst_rsp_word",  64'({rsp_err, rsp_tag, rsp_result}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_req_ready", 64'(req_ready), 64'd1);

        // ADD 0.5 + -0.4375, minimum latency and single dval pulse.
        $display("[TB] ADD single op");
        clearLogs();
        rsp_ready = 1'b1;
        applyStimulus(CMD_FPU_SP_ADD, 32'h3F000000, 32'hBEE00000, 4'd3, acc);
        waitRsp(1, 20);
        lat = (rspCycles.size() > 0) ? rspCycles[0] - acc : -1;
        checkOutput("add_entry",   64'(popEntry()), 64'({1'b0, 4'd3, 32'h3D800000}));
        checkOutput("add_latency", 64'(lat), 64'd4);
        repeat (3) @(negedge clk);
        checkOutput("add_dval_count", 64'(dvalCycles.size()), 64'd1);

        // MUL then I2F back to back; second dval must follow the first rdy.
        $display("[TB] MUL then I2F");
        clearLogs();
        applyStimulus(CMD_FPU_SP_MUL, 32'h3F000000, 32'hBEE00000, 4'd5, acc);
        applyStimulus(CMD_FPU_SP_I2F, 32'h00000005, 32'h00000000, 4'd6, acc);
        waitRsp(2, 40);
        checkOutput("mul_entry", 64'(popEntry()), 64'({1'b0, 4'd5, 32'hBE600000}));
        checkOutput("i2f_entry", 64'(popEntry()), 64'({1'b0, 4'd6, 32'h40A00000}));
        if (dvalCycles.size() == 2 && rdyCycles.size() >= 1)
            checkOutput("dval_after_rdy", 64'(dvalCycles[1] > rdyCycles[0]), 64'd1);
        else
            checkOutput("dval_count_2", 64'(dvalCycles.size()), 64'd2);

        // Withheld rdy: abort decided 64 cycles after dval, visible 2 cycles later.
        $display("[TB] timeout");
        clearLogs();
        withholdRdy = 1'b1;
        applyStimulus(CMD_FPU_SP_ADD, 32'h3F000000, 32'hBEE00000, 4'd7, acc);
        waitRsp(1, 120);
        lat = (rspCycles.size() > 0 && dvalCycles.size() > 0) ? rspCycles[0] - dvalCycles[0] : -1;
        checkOutput("timeout_entry",   64'(popEntry()), 64'({1'b1, 4'd7, 32'h0}));
        checkOutput("timeout_latency", 64'(lat), 64'(TIMEOUT + 2));
        repeat (8) @(posedge clk);
        #1 fpu_rdy = 1'b1;
        @(posedge clk);
        #1 fpu_rdy = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("late_rdy_no_rsp", 64'({rsp_valid, 32'(rspQ.size())}), 64'd0);
        withholdRdy = 1'b0;

        // Illegal command: no dval, error response 2 cycles after accept.
        $display("[TB] illegal command");
        clearLogs();
        rsp_ready = 1'b0;
        applyStimulus(4'hF, 32'h12345678, 32'h9ABCDEF0, 4'd9, acc);
        @(negedge clk);
        checkOutput("illegal_n1_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        checkOutput("illegal_n2_word", 64'({rsp_valid, rsp_err, rsp_tag, rsp_result}),
                    64'({1'b1, 1'b1, 4'd9, 32'h0}));
        checkOutput("illegal_no_dval", 64'(dvalCycles.size()), 64'd0);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        waitRsp(1, 10);
        void'(popEntry());
        @(posedge clk);
        #1 rsp_ready = 1'b0;

        // Backpressure: four buffered responses block the fifth request until one pop.
        $display("[TB] full FIFO backpressure");
        clearLogs();
        for (int t = 0; t < 4; t++)
            applyStimulus(CMD_FPU_SP_ADD, 32'h3F800000, 32'h3F800000, 4'(t), acc);
        repeat (6) @(negedge clk);
        fork
            applyStimulus(CMD_FPU_SP_ADD, 32'h3F800000, 32'h3F800000, 4'd4, acc);
            begin
                sawReady = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    if (req_ready) sawReady = 1'b1;
                end
                checkOutput("full_req_ready", 64'(sawReady), 64'd0);
                checkOutput("full_head", 64'({rsp_valid, rsp_tag}), 64'({1'b1, 4'd0}));
                checkOutput("full_dval_count", 64'(dvalCycles.size()), 64'd4);
                @(posedge clk);
                #1 rsp_ready = 1'b1;
                @(posedge clk);
                #1 rsp_ready = 1'b0;
            end
        join
        repeat (6) @(negedge clk);
        checkOutput("fifth_dval", 64'(dvalCycles.size()), 64'd5);
        rsp_ready = 1'b1;
        waitRsp(5, 40);
        for (int t = 0; t < 5; t++)
            checkOutput($sformatf("order_entry_%0d", t), 64'(popEntry()), 64'({1'b0, 4'(t), 32'h40000000}));
        @(posedge clk);
        #1 rsp_ready = 1'b0;

        // Reset during WAIT with two entries buffered.
        $display("[TB] reset mid-operation");
        clearLogs();
        applyStimulus(CMD_FPU_SP_ADD, 32'h3F800000, 32'h3F800000, 4'd1, acc);
        applyStimulus(CMD_FPU_SP_ADD, 32'h3F800000, 32'h3F800000, 4'd2, acc);
        repeat (4) @(negedge clk);
        withholdRdy = 1'b1;
        applyStimulus(CMD_FPU_SP_ADD, 32'h3F800000, 32'h3F800000, 4'd3, acc);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_state", 64'({rsp_valid, req_ready, fpu_dval}), 64'({1'b0, 1'b1, 1'b0}));
        @(posedge clk);
        #1 fpu_rdy = 1'b1;
        @(posedge clk);
        #1 fpu_rdy = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("post_rst_late_rdy", 64'(rsp_valid), 64'd0);
        withholdRdy = 1'b0;
        clearLogs();
        rsp_ready = 1'b1;
        applyStimulus(CMD_FPU_SP_ADD, 32'h3F000000, 32'hBEE00000, 4'd4, acc);
        waitRsp(1, 20);
        lat = (rspCycles.size() > 0) ? rspCycles[0] - acc : -1;
        checkOutput("post_rst_entry",   64'(popEntry()), 64'({1'b0, 4'd4, 32'h3D800000}));
        checkOutput("post_rst_latency", 64'(lat), 64'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
